// File: rtl/popcount_accumulator.sv
// ============================================================================
// Module   : popcount_accumulator
// Purpose  : Pipelined adder-tree popcount that sums the per-beat counts of a
//            packet and emits one saturated packet total.
//            Optional feature macro: POPCOUNT_XNOR_EN (adds s_weight, XNOR-popcount).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_accumulator #(
    parameter int DATA_WIDTH  = 64,
    parameter int PIPE_STAGES = 2,
    parameter int ACC_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
`ifdef POPCOUNT_XNOR_EN
    input  logic [DATA_WIDTH-1:0] s_weight,
`endif
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ACC_WIDTH-1:0]  m_count,
    output logic                  m_overflow
);

    localparam int c_levels = $clog2(DATA_WIDTH);
    localparam int c_pc_w   = c_levels + 1;

    logic                  stall_w;
    logic [DATA_WIDTH-1:0] bits_w;
    logic                  in_valid_w;
    logic                  in_last_w;

    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic                  m_valid_q, m_valid_d;
    logic [ACC_WIDTH-1:0]  m_count_q, m_count_d;
    logic                  m_overflow_q, m_overflow_d;

    // A waiting result freezes the whole pipe, so nothing is ever dropped.
    assign stall_w    = m_valid_q & ~m_ready;
    assign s_ready    = ~stall_w;
    assign in_valid_w = s_valid & ~stall_w;
    assign in_last_w  = s_last;

`ifdef POPCOUNT_XNOR_EN
    assign bits_w = ~(s_data ^ s_weight);
`else
    assign bits_w = s_data;
`endif

    // Level k adds pairs from level k-1; a register follows level k whenever
    // floor(k*P/L) steps, which spreads the P registers evenly over L levels.
    genvar k;
    generate
        for (k = 1; k <= c_levels; k++) begin : g_lvl
            localparam int c_n   = DATA_WIDTH >> k;
            localparam bit c_reg = ((k * PIPE_STAGES) / c_levels) !=
                                   (((k - 1) * PIPE_STAGES) / c_levels);

            logic [k-1:0] a_w    [2*c_n];
            logic [k:0]   sum_d  [c_n];
            logic [k:0]   node_w [c_n];
            logic         valid_d, last_d;
            logic         valid_w, last_w;

            if (k == 1) begin : g_first
                always_comb begin
                    for (int j = 0; j < 2 * c_n; j++) begin
                        a_w[j] = bits_w[j];
                    end
                end
                assign valid_d = in_valid_w;
                assign last_d  = in_last_w;
            end else begin : g_inner
                assign a_w     = g_lvl[k-1].node_w;
                assign valid_d = g_lvl[k-1].valid_w;
                assign last_d  = g_lvl[k-1].last_w;
            end

            always_comb begin
                for (int i = 0; i < c_n; i++) begin
                    sum_d[i] = {1'b0, a_w[2*i]} + {1'b0, a_w[2*i+1]};
                end
            end

            if (c_reg) begin : g_reg
                logic [k:0] node_q [c_n];
                logic       valid_q, last_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        for (int i = 0; i < c_n; i++) begin
                            node_q[i] <= '0;
                        end
                    end else if (!stall_w) begin
                        valid_q <= valid_d;
                        last_q  <= last_d;
                        node_q  <= sum_d;
                    end
                end

                assign node_w  = node_q;
                assign valid_w = valid_q;
                assign last_w  = last_q;
            end else begin : g_comb
                assign node_w  = sum_d;
                assign valid_w = valid_d;
                assign last_w  = last_d;
            end
        end
    endgenerate

    logic [c_pc_w-1:0]  pc_w;
    logic               tree_valid_w, tree_last_w;
    logic [ACC_WIDTH:0] sum_w;
    logic [ACC_WIDTH-1:0] sat_w;

    assign pc_w         = g_lvl[c_levels].node_w[0];
    assign tree_valid_w = g_lvl[c_levels].valid_w;
    assign tree_last_w  = g_lvl[c_levels].last_w;

    assign sum_w = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - c_pc_w){1'b0}}, pc_w};
    assign sat_w = sum_w[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];

    always_comb begin
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        m_valid_d    = m_valid_q;
        m_count_d    = m_count_q;
        m_overflow_d = m_overflow_q;
        if (!stall_w) begin
            // Not stalled means any held result is being taken this edge.
            m_valid_d = 1'b0;
            if (tree_valid_w) begin
                if (tree_last_w) begin
                    m_count_d    = sat_w;
                    m_overflow_d = ovf_q | sum_w[ACC_WIDTH];
                    m_valid_d    = 1'b1;
                    acc_d        = '0;
                    ovf_d        = 1'b0;
                end else begin
                    acc_d = sat_w;
                    ovf_d = ovf_q | sum_w[ACC_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            m_valid_q    <= 1'b0;
            m_count_q    <= '0;
            m_overflow_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            m_valid_q    <= m_valid_d;
            m_count_q    <= m_count_d;
            m_overflow_q <= m_overflow_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_count    = m_count_q;
    assign m_overflow = m_overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_popcount_accumulator.sv
// ============================================================================
// Module   : tb_popcount_accumulator
// Purpose  : Self-checking bench: vector table, corner sequences, random
//            traffic against a packet-sum scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_popcount_accumulator;

    localparam int DW  = 64;
    localparam int PS  = 2;
    localparam int AW  = 16;
    localparam int AW7 = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready, m_overflow;
    logic [AW-1:0] m_count;

    logic           s7_valid, s7_ready, s7_last;
    logic [DW-1:0]  s7_data;
    logic           m7_valid, m7_ready, m7_overflow;
    logic [AW7-1:0] m7_count;

`ifdef POPCOUNT_XNOR_EN
    logic [DW-1:0] s_weight, s7_weight;
`endif

    popcount_accumulator #(.DATA_WIDTH(DW), .PIPE_STAGES(PS), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef POPCOUNT_XNOR_EN
        .s_weight(s_weight),
`endif
        .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count), .m_overflow(m_overflow)
    );

    popcount_accumulator #(.DATA_WIDTH(DW), .PIPE_STAGES(PS), .ACC_WIDTH(AW7)) dut7 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s7_valid), .s_ready(s7_ready), .s_data(s7_data),
`ifdef POPCOUNT_XNOR_EN
        .s_weight(s7_weight),
`endif
        .s_last(s7_last),
        .m_valid(m7_valid), .m_ready(m7_ready), .m_count(m7_count), .m_overflow(m7_overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a packet's result is its total bit count, clipped at the max.
    typedef struct { logic [AW-1:0] cnt; logic ovf; } res_t;
    res_t             exp_q[$];
    logic [AW-1:0]    got_q[$];
    longint unsigned  model_total = 0;
    int               pulses = 0;
    logic [AW-1:0]    last_cnt;
    logic             holding = 1'b0;
    logic [AW-1:0]    hold_cnt;
    logic             hold_ovf;

    function automatic int beat_pc(input logic [DW-1:0] d);
`ifdef POPCOUNT_XNOR_EN
        return $countones(~(d ^ s_weight));
`else
        return $countones(d);
`endif
    endfunction

    initial begin : monitor
        res_t r;
        longint unsigned maxv;
        maxv = (64'd1 << AW) - 1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_total = 0;
                exp_q.delete();
                holding = 1'b0;
            end else begin
                check("s_ready_vs_stall", s_ready, !(m_valid && !m_ready));
                if (holding && m_valid) begin
                    check("stall_hold_count", m_count, hold_cnt);
                    check("stall_hold_ovf", m_overflow, hold_ovf);
                end
                holding  = m_valid && !m_ready;
                hold_cnt = m_count;
                hold_ovf = m_overflow;
                if (m_valid && m_ready) begin
                    pulses++;
                    last_cnt = m_count;
                    got_q.push_back(m_count);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got count %0d with no packet pending", m_count);
                    end else begin
                        r = exp_q.pop_front();
                        check("sb_count", m_count, r.cnt);
                        check("sb_ovf", m_overflow, r.ovf);
                    end
                end
                if (s_valid && s_ready) begin
                    model_total += longint'(beat_pc(s_data));
                    if (s_last) begin
                        r.cnt = (model_total > maxv) ? AW'(maxv) : AW'(model_total);
                        r.ovf = (model_total > maxv);
                        exp_q.push_back(r);
                        model_total = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        bit acc;
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        acc = 1'b0;
        n = 0;
        while (!acc) begin
            @(negedge clk);
            acc = s_ready;
            tick();
            n++;
            if (!acc && n > 60) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: beat not accepted after %0d cycles", n);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!m_valid && n < 30) begin
            tick();
            n++;
        end
        if (!m_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: m_valid never rose within %0d cycles", name, n);
        end
    endtask

    typedef struct { logic [DW-1:0] data; logic last; int exp_cnt; } vec_t;
    vec_t tbl[10];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int k;
        int r7_n;
        logic [AW7-1:0] r7_cnt[4];
        logic           r7_ovf[4];
        bit done;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        s7_valid = 1'b0; s7_data = '0; s7_last = 1'b0; m7_ready = 1'b1;
`ifdef POPCOUNT_XNOR_EN
        s_weight = '1; s7_weight = '1;
`endif
        repeat (3) tick();
        check("reset_m_valid", m_valid, 0);
        check("reset_m_count", m_count, 0);
        check("reset_m_overflow", m_overflow, 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_s_ready", s_ready, 1);

        // Latency: accept edge counts as edge 1, result after edge PS+1.
        send('1, 1'b1);
        n = 1;
        while (!m_valid && n < 20) begin tick(); n++; end
        check("latency_edges", n, PS + 1);
        check("allones_count", m_count, 64);
        check("allones_ovf", m_overflow, 0);
        idle(8);

        pulses = 0;
        send(64'h1, 1'b0); send(64'h3, 1'b0); send(64'hF0, 1'b0); send(64'h0, 1'b1);
        idle(10);
        check("four_beat_pulses", pulses, 1);
        check("four_beat_count", last_cnt, 7);

        // Back-to-back with a held result and a handover edge.
        m_ready = 1'b0;
        send(64'hFF, 1'b1);
        send(64'hFFFF, 1'b1);
        wait_valid("stall_first", n);
        for (int i = 0; i < 5; i++) begin
            check("stall_s_ready", s_ready, 0);
            check("stall_m_valid", m_valid, 1);
            check("stall_count8", m_count, 8);
            tick();
        end
        m_ready = 1'b1;
        tick();
        check("handover_valid", m_valid, 1);
        check("handover_count16", m_count, 16);
        idle(6);

        // Saturating narrow accumulator.
        s7_valid = 1'b1; s7_data = '1; s7_last = 1'b0;
        check("acc7_s_ready", s7_ready, 1);
        tick(); tick();
        s7_last = 1'b1; tick();
        s7_data = 64'h1; tick();
        s7_valid = 1'b0; s7_last = 1'b0;
        r7_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (m7_valid && r7_n < 4) begin
                r7_cnt[r7_n] = m7_count;
                r7_ovf[r7_n] = m7_overflow;
                r7_n++;
            end
            tick();
        end
        check("acc7_results", r7_n, 2);
        if (r7_n >= 2) begin
            check("acc7_sat_count", r7_cnt[0], 127);
            check("acc7_sat_ovf", r7_ovf[0], 1);
            check("acc7_next_count", r7_cnt[1], 1);
            check("acc7_next_ovf", r7_ovf[1], 0);
        end

        // Reset in the middle of a packet.
        send('1, 1'b0); send('1, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("midreset_m_valid", m_valid, 0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        send(64'h5, 1'b1);
        wait_valid("after_reset", n);
        check("after_reset_count", m_count, 2);
        check("after_reset_ovf", m_overflow, 0);
        idle(6);

`ifdef POPCOUNT_XNOR_EN
        s_weight = 64'h0000_0000_FFFF_FFFF;
        send(64'h0, 1'b1);
        s_weight = '1;
        wait_valid("xnor", n);
        check("xnor_count", m_count, 32);
        idle(6);
`endif

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64};
        tbl[1] = '{64'h1,                   1'b0, 0};
        tbl[2] = '{64'h3,                   1'b0, 0};
        tbl[3] = '{64'hF0,                  1'b0, 0};
        tbl[4] = '{64'h0,                   1'b1, 7};
        tbl[5] = '{64'h8000_0000_0000_0001, 1'b1, 2};
        tbl[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 0};
        tbl[7] = '{64'h5555_5555_5555_5555, 1'b1, 64};
        tbl[8] = '{64'h0,                   1'b1, 0};
        tbl[9] = '{64'h0123_4567_89AB_CDEF, 1'b1, 32};
        got_q.delete();
        for (int i = 0; i < 10; i++) send(tbl[i].data, tbl[i].last);
        idle(12);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].last) begin
                if (k < got_q.size()) check($sformatf("table_%0d", i), got_q[k], tbl[i].exp_cnt);
                else check($sformatf("table_%0d_missing", i), got_q.size(), k + 1);
                k++;
            end
        end

        // Random traffic with bubbles and back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        s_data = {$urandom, $urandom};
                        s_last = 1'($urandom_range(0, 1));
                        s_valid = 1'b0;
                        tick();
                    end else if ($urandom_range(0, 7) == 0) begin
                        send('1, 1'($urandom_range(0, 3) == 0));
                    end else begin
                        send({$urandom, $urandom}, 1'($urandom_range(0, 3) == 0));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    m_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        m_ready = 1'b1;
        send(64'h1, 1'b1);
        idle(15);
        check("sb_drained", exp_q.size(), 0);
        check("final_m_valid", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
